// File: rtl/i2f_sched.sv
// i2f_sched: round-robin scheduler sharing one i2f fixed-to-bfloat16 converter among NREQ
// requesters. One job is in flight at a time: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
// Optional WAIT-state watchdog is compiled in by defining I2F_SCHED_TIMEOUT_EN.
module i2f_sched #(
  parameter int unsigned NREQ           = 4,
  parameter int unsigned EXP_WIDTH      = 8,
  parameter int unsigned FRACT_WIDTH    = 7,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NREQ-1:0]             req_i,
  input  logic [NREQ*EXP_WIDTH-1:0]   int_i,
  input  logic [NREQ*FRACT_WIDTH-1:0] frac_i,
  output logic [NREQ-1:0]             gnt_o,
  output logic [NREQ-1:0]             resp_valid_o,
  output logic [EXP_WIDTH-1:0]        resp_exp_o,
  output logic [FRACT_WIDTH-1:0]      resp_fract_o,
  output logic                        resp_sgn_o,
  output logic                        resp_err_o,
  output logic                        busy_o,
  output logic                        cvt_valid_o,
  output logic [EXP_WIDTH-1:0]        cvt_int_o,
  output logic [FRACT_WIDTH-1:0]      cvt_frac_o,
  input  logic                        cvt_valid_i,
  input  logic [EXP_WIDTH-1:0]        cvt_exp_i,
  input  logic [FRACT_WIDTH-1:0]      cvt_fract_i,
  input  logic                        cvt_sgn_i
);

  localparam int unsigned IdxW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e                 state_q, state_d;
  logic [IdxW-1:0]        ptr_q, ptr_d;
  logic [IdxW-1:0]        idx_q, idx_d;
  logic [NREQ-1:0]        gnt_q, gnt_d;
  logic [NREQ-1:0]        resp_valid_q, resp_valid_d;
  logic [EXP_WIDTH-1:0]   resp_exp_q, resp_exp_d;
  logic [FRACT_WIDTH-1:0] resp_fract_q, resp_fract_d;
  logic                   resp_sgn_q, resp_sgn_d;
  logic                   busy_q, busy_d;
  logic                   cvt_valid_q, cvt_valid_d;
  logic [EXP_WIDTH-1:0]   cvt_int_q, cvt_int_d;
  logic [FRACT_WIDTH-1:0] cvt_frac_q, cvt_frac_d;

`ifdef I2F_SCHED_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CntW-1:0] wd_q, wd_d;
  logic            resp_err_q, resp_err_d;
`endif

  logic            arb_found;
  logic [IdxW-1:0] arb_idx;
  int unsigned     cand;

  // Round-robin pick: first set request searching cyclically from ptr+1.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    cand      = 0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      cand = 32'(ptr_q) + i;
      if (cand >= NREQ) cand = cand - NREQ;
      if (!arb_found && req_i[IdxW'(cand)]) begin
        arb_found = 1'b1;
        arb_idx   = IdxW'(cand);
      end
    end
  end

  // Next-state and registered-output logic for the job FSM.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    idx_d        = idx_q;
    gnt_d        = '0;
    resp_valid_d = '0;
    cvt_valid_d  = 1'b0;
    cvt_int_d    = cvt_int_q;
    cvt_frac_d   = cvt_frac_q;
    resp_exp_d   = resp_exp_q;
    resp_fract_d = resp_fract_q;
    resp_sgn_d   = resp_sgn_q;
`ifdef I2F_SCHED_TIMEOUT_EN
    wd_d         = wd_q;
    resp_err_d   = resp_err_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (arb_found) begin
          idx_d          = arb_idx;
          cvt_int_d      = int_i[arb_idx*EXP_WIDTH +: EXP_WIDTH];
          cvt_frac_d     = frac_i[arb_idx*FRACT_WIDTH +: FRACT_WIDTH];
          gnt_d[arb_idx] = 1'b1;
          cvt_valid_d    = 1'b1;
          state_d        = StIssue;
        end
      end
      StIssue: begin
`ifdef I2F_SCHED_TIMEOUT_EN
        wd_d    = '0;
`endif
        state_d = StWait;
      end
      StWait: begin
`ifdef I2F_SCHED_TIMEOUT_EN
        wd_d = wd_q + CntW'(1);
`endif
        // A done pulse wins over a watchdog expiry in the same cycle.
        if (cvt_valid_i) begin
          resp_exp_d          = cvt_exp_i;
          resp_fract_d        = cvt_fract_i;
          resp_sgn_d          = cvt_sgn_i;
          resp_valid_d[idx_q] = 1'b1;
          state_d             = StResp;
`ifdef I2F_SCHED_TIMEOUT_EN
          resp_err_d          = 1'b0;
        end else if (wd_d == CntW'(TIMEOUT_CYCLES)) begin
          resp_exp_d          = '0;
          resp_fract_d        = '0;
          resp_sgn_d          = 1'b0;
          resp_err_d          = 1'b1;
          resp_valid_d[idx_q] = 1'b1;
          state_d             = StResp;
`endif
        end
      end
      StResp: begin
        ptr_d   = idx_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      ptr_q        <= IdxW'(NREQ - 1);
      idx_q        <= '0;
      gnt_q        <= '0;
      resp_valid_q <= '0;
      resp_exp_q   <= '0;
      resp_fract_q <= '0;
      resp_sgn_q   <= 1'b0;
      busy_q       <= 1'b0;
      cvt_valid_q  <= 1'b0;
      cvt_int_q    <= '0;
      cvt_frac_q   <= '0;
`ifdef I2F_SCHED_TIMEOUT_EN
      wd_q         <= '0;
      resp_err_q   <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      idx_q        <= idx_d;
      gnt_q        <= gnt_d;
      resp_valid_q <= resp_valid_d;
      resp_exp_q   <= resp_exp_d;
      resp_fract_q <= resp_fract_d;
      resp_sgn_q   <= resp_sgn_d;
      busy_q       <= busy_d;
      cvt_valid_q  <= cvt_valid_d;
      cvt_int_q    <= cvt_int_d;
      cvt_frac_q   <= cvt_frac_d;
`ifdef I2F_SCHED_TIMEOUT_EN
      wd_q         <= wd_d;
      resp_err_q   <= resp_err_d;
`endif
    end
  end

  assign gnt_o        = gnt_q;
  assign resp_valid_o = resp_valid_q;
  assign resp_exp_o   = resp_exp_q;
  assign resp_fract_o = resp_fract_q;
  assign resp_sgn_o   = resp_sgn_q;
  assign busy_o       = busy_q;
  assign cvt_valid_o  = cvt_valid_q;
  assign cvt_int_o    = cvt_int_q;
  assign cvt_frac_o   = cvt_frac_q;

`ifdef I2F_SCHED_TIMEOUT_EN
  assign resp_err_o = resp_err_q;
`else
  // No watchdog: a result can never be invalid. TIMEOUT_CYCLES is still referenced so the
  // parameter list is identical in both builds.
  assign resp_err_o = (TIMEOUT_CYCLES == 0) ? 1'b0 : 1'b0;
`endif

endmodule

// File: tb/tb_i2f_sched.sv
// Bench for i2f_sched: directed steps plus a randomized phase, checked against a
// transaction-level model (pending set + last-served index) and a converter model.
`timescale 1ns/1ps
module tb_i2f_sched;
  localparam int unsigned NREQ = 4;
  localparam int unsigned EW   = 8;
  localparam int unsigned FW   = 7;
  localparam int unsigned TO   = 8;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NREQ-1:0]      req_i;
  logic [NREQ*EW-1:0]   int_i;
  logic [NREQ*FW-1:0]   frac_i;
  logic [NREQ-1:0]      gnt_o, resp_valid_o;
  logic [EW-1:0]        resp_exp_o, cvt_int_o;
  logic [FW-1:0]        resp_fract_o, cvt_frac_o;
  logic                 resp_sgn_o, resp_err_o, busy_o, cvt_valid_o;
  logic                 cvt_valid_i = 1'b0;
  logic [EW-1:0]        cvt_exp_i = '0;
  logic [FW-1:0]        cvt_fract_i = '0;
  logic                 cvt_sgn_i = 1'b0;

  always #5 clk = ~clk;

  i2f_sched #(
    .NREQ(NREQ), .EXP_WIDTH(EW), .FRACT_WIDTH(FW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .int_i(int_i), .frac_i(frac_i),
    .gnt_o(gnt_o), .resp_valid_o(resp_valid_o), .resp_exp_o(resp_exp_o),
    .resp_fract_o(resp_fract_o), .resp_sgn_o(resp_sgn_o), .resp_err_o(resp_err_o),
    .busy_o(busy_o), .cvt_valid_o(cvt_valid_o), .cvt_int_o(cvt_int_o),
    .cvt_frac_o(cvt_frac_o), .cvt_valid_i(cvt_valid_i), .cvt_exp_i(cvt_exp_i),
    .cvt_fract_i(cvt_fract_i), .cvt_sgn_i(cvt_sgn_i)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Signed 8.7 fixed point -> {sgn, bf16 exponent, 7-bit fraction}, truncating.
  function automatic logic [15:0] conv(input logic [7:0] iv, input logic [6:0] fv);
    int v, mag, p;
    logic sgn;
    v = int'($signed({iv, fv}));
    sgn = (v < 0);
    mag = sgn ? -v : v;
    if (mag == 0) return 16'h0;
    p = 0;
    for (int b = 0; b < 16; b++) if (mag[b]) p = b;
    return {sgn, 8'(127 + p - 7), 7'((mag << (15 - p)) >> 8)};
  endfunction

  // Converter model: done after a configurable latency; stray pulses while scheduler is idle.
  bit   cvt_en = 1'b1;
  int   cvt_lat = -1;
  bit   cvt_busy = 1'b0;
  int   cvt_cnt = 0;
  int   done_cyc = -1;
  logic [EW-1:0] cvt_opi;
  logic [FW-1:0] cvt_opf;
  always @(negedge clk) begin
    #1;
    cvt_valid_i = 1'b0;
    cvt_exp_i   = 8'($urandom);
    cvt_fract_i = 7'($urandom);
    cvt_sgn_i   = 1'($urandom);
    if (rst) cvt_busy = 1'b0;
    else if (cvt_busy) begin
      if (cvt_cnt == 0) begin
        {cvt_sgn_i, cvt_exp_i, cvt_fract_i} = conv(cvt_opi, cvt_opf);
        cvt_valid_i = 1'b1;
        cvt_busy    = 1'b0;
        done_cyc    = cyc;
      end else cvt_cnt--;
    end else if (!busy_o && $urandom_range(0, 3) == 0) cvt_valid_i = 1'b1;
    if (cvt_valid_o && !rst) begin
      cvt_busy = cvt_en;
      cvt_cnt  = (cvt_lat < 0) ? int'($urandom_range(0, 4)) : cvt_lat;
      cvt_opi  = cvt_int_o;
      cvt_opf  = cvt_frac_o;
    end
  end

  // Reference model state.
  logic [EW-1:0] opi[NREQ];
  logic [FW-1:0] opf[NREQ];
  bit            pend[NREQ];
  int            last;
  logic [EW-1:0] g_int;
  logic [FW-1:0] g_frac;

  task automatic apply();
    for (int k = 0; k < NREQ; k++) begin
      req_i[k]              = pend[k];
      int_i[k*EW +: EW]     = opi[k];
      frac_i[k*FW +: FW]    = opf[k];
    end
  endtask

  function automatic int winner();
    for (int i = 1; i <= NREQ; i++) begin
      int k = (last + i) % NREQ;
      if (pend[k]) return k;
    end
    return -1;
  endfunction

  task automatic issue_part(input int exp_gap, output int w, output int icyc);
    bit seen;
    int tg;
    w = winner();
    seen = 0; tg = -1; icyc = -1;
    for (int t = 0; t < 30; t++) begin
      @(negedge clk);
      if (gnt_o != '0) begin seen = 1; tg = t; break; end
    end
    chk("gnt_seen", 32'(seen), 1);
    if (!seen || w < 0) begin w = -1; return; end
    icyc = cyc;
    chk("gnt_winner", gnt_o, 32'(1) << w);
    if (exp_gap >= 0) chk("gnt_gap", tg, exp_gap);
    chk("cvt_valid_issue", cvt_valid_o, 1);
    chk("cvt_int", cvt_int_o, opi[w]);
    chk("cvt_frac", cvt_frac_o, opf[w]);
    chk("busy_issue", busy_o, 1);
    g_int = opi[w]; g_frac = opf[w];
    // Requester drops its request after the grant; operands become don't-care.
    pend[w] = 0; opi[w] = 8'($urandom); opf[w] = 7'($urandom);
    apply();
    @(negedge clk);
    chk("gnt_one_cycle", gnt_o, 0);
    chk("cvt_valid_one_cycle", cvt_valid_o, 0);
  endtask

  task automatic resp_part(input int w, input int icyc, input bit exp_err);
    bit seen;
    logic [15:0] r;
    seen = 0;
    for (int t = 0; t < 60; t++) begin
      if (resp_valid_o != '0) begin seen = 1; break; end
      @(negedge clk);
    end
    chk("resp_seen", 32'(seen), 1);
    if (!seen) return;
    chk("resp_target", resp_valid_o, 32'(1) << w);
    chk("resp_err", resp_err_o, 32'(exp_err));
    chk("cvt_int_hold", cvt_int_o, g_int);
    chk("cvt_frac_hold", cvt_frac_o, g_frac);
    if (exp_err) begin
      chk("resp_result_err", {resp_sgn_o, resp_exp_o, resp_fract_o}, 0);
      chk("timeout_latency", cyc, icyc + TO + 1);
    end else begin
      r = conv(g_int, g_frac);
      chk("resp_result", {resp_sgn_o, resp_exp_o, resp_fract_o}, r);
      chk("resp_latency", cyc, done_cyc + 1);
    end
    last = w;
  endtask

  task automatic do_job(input int exp_gap, input bit exp_err);
    int w, icyc;
    issue_part(exp_gap, w, icyc);
    if (w >= 0) resp_part(w, icyc, exp_err);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int w, icyc, nset;
    rst = 1'b1; req_i = '0; int_i = '0; frac_i = '0; last = NREQ - 1;
    for (int k = 0; k < NREQ; k++) begin pend[k] = 0; opi[k] = '0; opf[k] = '0; end
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_gnt", gnt_o, 0);
    chk("rst_resp_valid", resp_valid_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_cvt_valid", cvt_valid_o, 0);
    chk("rst_cvt_ops", {cvt_int_o, cvt_frac_o}, 0);
    chk("rst_resp", {resp_err_o, resp_sgn_o, resp_exp_o, resp_fract_o}, 0);
    rst = 1'b0;
    @(negedge clk);

    // Single request: 5.0 -> exp 0x81, fract 0x20
    opi[0] = 8'h05; opf[0] = 7'h00; pend[0] = 1; apply();
    do_job(-1, 0);
    chk("single_exp", resp_exp_o, 8'h81);
    chk("single_fract", resp_fract_o, 7'h20);
    chk("single_sgn", resp_sgn_o, 0);
    @(negedge clk);
    chk("idle_busy", busy_o, 0);
    chk("resp_one_cycle", resp_valid_o, 0);
    chk("resp_exp_hold", resp_exp_o, 8'h81);

    // Negative operand: -3.0 on requester 2
    opi[2] = 8'hFD; opf[2] = 7'h00; pend[2] = 1; apply();
    do_job(-1, 0);
    chk("neg_exp", resp_exp_o, 8'h80);
    chk("neg_fract", resp_fract_o, 7'h40);
    chk("neg_sgn", resp_sgn_o, 1);

    // Fairness: all requesters held high; re-raise in the RESP cycle
    for (int j = 0; j < 6; j++) begin
      for (int k = 0; k < NREQ; k++) if (!pend[k]) begin
        pend[k] = 1; opi[k] = 8'($urandom); opf[k] = 7'($urandom);
      end
      apply();
      do_job(j == 0 ? -1 : 1, 0);
    end
    for (int k = 0; k < NREQ; k++) pend[k] = 0;
    apply();

    // Withdrawal: requester 1 pulses req for one cycle while job 0 is in WAIT
    repeat (2) @(negedge clk);
    cvt_lat = 6;
    opi[0] = 8'($urandom); opf[0] = 7'($urandom); pend[0] = 1; apply();
    issue_part(-1, w, icyc);
    req_i[1] = 1'b1;
    @(negedge clk);
    req_i[1] = 1'b0;
    if (w >= 0) resp_part(w, icyc, 0);
    cvt_lat = -1;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      chk("withdraw_no_gnt", gnt_o, 0);
      chk("withdraw_no_resp", resp_valid_o, 0);
    end
    chk("withdraw_idle", busy_o, 0);

    // Reset during WAIT discards the job; requester 0 wins first afterwards
    cvt_lat = 10;
    opi[2] = 8'($urandom); opf[2] = 7'($urandom); pend[2] = 1; apply();
    issue_part(-1, w, icyc);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    last = NREQ - 1;
    cvt_lat = -1;
    chk("midrst_outputs", {gnt_o, resp_valid_o, cvt_valid_o, resp_err_o}, 0);
    chk("midrst_data", {cvt_int_o, cvt_frac_o, resp_sgn_o, resp_exp_o, resp_fract_o}, 0);
    chk("midrst_busy", busy_o, 0);
    for (int t = 0; t < 12; t++) begin
      @(negedge clk);
      chk("midrst_no_resp", resp_valid_o, 0);
    end
    opi[0] = 8'($urandom); opf[0] = 7'($urandom); pend[0] = 1;
    opi[3] = 8'($urandom); opf[3] = 7'($urandom); pend[3] = 1;
    apply();
    do_job(-1, 0);
    chk("midrst_first_winner", last, 0);
    do_job(1, 0);

    // Randomized traffic with occasional withdrawals before grant
    for (int j = 0; j < 30; j++) begin
      nset = 0;
      for (int k = 0; k < NREQ; k++) begin
        if (!pend[k] && $urandom_range(0, 1) == 1) begin
          pend[k] = 1; opi[k] = 8'($urandom); opf[k] = 7'($urandom);
        end else if (pend[k] && $urandom_range(0, 7) == 0) pend[k] = 0;
        if (pend[k]) nset++;
      end
      if (nset == 0) begin
        w = int'($urandom_range(0, NREQ - 1));
        pend[w] = 1; opi[w] = 8'($urandom); opf[w] = 7'($urandom);
      end
      apply();
      do_job(1, 0);
    end
    for (int k = 0; k < NREQ; k++) pend[k] = 0;
    apply();

`ifdef I2F_SCHED_TIMEOUT_EN
    // Converter never answers: watchdog response with error, then normal service
    cvt_en = 1'b0;
    opi[1] = 8'($urandom); opf[1] = 7'($urandom); pend[1] = 1; apply();
    do_job(-1, 1);
    cvt_en = 1'b1;
    opi[2] = 8'($urandom); opf[2] = 7'($urandom); pend[2] = 1; apply();
    do_job(1, 0);
    pend[2] = 0; apply();
`endif

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
